// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc: parametrised multi-cycle Hack CPU with valid/ready instruction and data buses.
// Optional feature macro HALT_DETECT_EN: a taken self-jump halts the core until reset.
module hack_cpu_mc #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       instret,
  output logic              halted
);
  typedef enum logic [2:0] {FETCH, DECODE, MREAD, EXEC, WB, HALT} state_t;

  state_t            state, stateNext;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir, regA, regD, regM, aluRes;
  logic [DATA_W-1:0] aluX, aluY, aluOut;
  logic              flagNg, flagZr, jump;
  logic              loadIr, loadM, retire, wbDone;
  logic              instrReqNext, memReqNext, memWeNext;
  logic              isC, destA, destD, destM;

  assign isC        = ir[DATA_W-1];
  assign destA      = ir[5];
  assign destD      = ir[4];
  assign destM      = ir[3];
  assign instr_addr = pc;
  assign mem_addr   = regA[ADDR_W-1:0];
  assign mem_wdata  = aluRes;
  assign jump       = (ir[2] & flagNg) | (ir[1] & flagZr) | (ir[0] & ~flagNg & ~flagZr);

`ifdef HALT_DETECT_EN
  logic selfJump;
  assign selfJump = jump && (regA[ADDR_W-1:0] == pc);
`endif

  // Hack ALU: x = D, y = A or M
  always_comb begin
    aluX = ir[11] ? '0 : regD;
    if (ir[10]) aluX = ~aluX;
    aluY = ir[12] ? regM : regA;
    if (ir[9]) aluY = '0;
    if (ir[8]) aluY = ~aluY;
    aluOut = ir[7] ? (aluX + aluY) : (aluX & aluY);
    if (ir[6]) aluOut = ~aluOut;
  end

  // Next state, datapath strobes and next bus request values
  always_comb begin
    stateNext = state;
    loadIr    = 1'b0;
    loadM     = 1'b0;
    retire    = 1'b0;
    wbDone    = 1'b0;
    case (state)
      FETCH: begin
        if (instr_req && instr_valid) begin
          loadIr    = 1'b1;
          stateNext = DECODE;
        end
      end
      DECODE: begin
        if (!isC) begin
          retire    = 1'b1;
          stateNext = FETCH;
        end else if (ir[12]) begin
          stateNext = MREAD;
        end else begin
          stateNext = EXEC;
        end
      end
      MREAD: begin
        if (mem_req && mem_ready) begin
          loadM     = 1'b1;
          stateNext = EXEC;
        end
      end
      EXEC: stateNext = WB;
      WB: begin
        if (!destM || (mem_req && mem_ready)) begin
          wbDone    = 1'b1;
          retire    = 1'b1;
          stateNext = FETCH;
`ifdef HALT_DETECT_EN
          if (selfJump) stateNext = HALT;
`endif
        end
      end
      HALT:    stateNext = HALT;
      default: stateNext = FETCH;
    endcase
    instrReqNext = (stateNext == FETCH);
    memReqNext   = (stateNext == MREAD) || ((stateNext == WB) && destM);
    memWeNext    = (stateNext == WB) && destM;
  end

  // State register; A and the jump target are read before this instruction's own update
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= FETCH;
      pc        <= ADDR_W'(RESET_VECTOR);
      ir        <= '0;
      regA      <= '0;
      regD      <= '0;
      regM      <= '0;
      aluRes    <= '0;
      flagNg    <= 1'b0;
      flagZr    <= 1'b0;
      instret   <= '0;
      instr_req <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      state     <= stateNext;
      instr_req <= instrReqNext;
      mem_req   <= memReqNext;
      mem_we    <= memWeNext;
      if (loadIr) ir <= instr_rdata;
      if (loadM) regM <= mem_rdata;
      if (state == EXEC) begin
        aluRes <= aluOut;
        flagNg <= aluOut[DATA_W-1];
        flagZr <= (aluOut == '0);
      end
      if (state == DECODE && !isC) begin
        regA <= {1'b0, ir[DATA_W-2:0]};
        pc   <= pc + ADDR_W'(1);
      end
      if (wbDone) begin
        if (destA) regA <= aluRes;
        if (destD) regD <= aluRes;
        pc <= jump ? regA[ADDR_W-1:0] : pc + ADDR_W'(1);
      end
      if (retire) instret <= instret + 32'd1;
    end
  end

`ifdef HALT_DETECT_EN
  always_ff @(posedge clk) begin
    if (!rstn) halted <= 1'b0;
    else if (wbDone && selfJump) halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Testbench for hack_cpu_mc: directed vector table, hand-written corner sequences and a
// randomized program run checked against an instruction-level reference model.
module tb_hack_cpu_mc;
  logic        clk, rstn;
  logic        instr_req, instr_valid, mem_req, mem_we, mem_ready, halted;
  logic [14:0] instr_addr, mem_addr;
  logic [15:0] instr_rdata, mem_wdata, mem_rdata;
  logic [31:0] instret;

  logic        rstn2, w_instr_req, w_instr_valid, w_mem_req, w_mem_we, w_mem_ready, w_halted;
  logic [19:0] w_instr_addr, w_mem_addr;
  logic [31:0] w_instr_rdata, w_mem_wdata, w_mem_rdata, w_instret;

  hack_cpu_mc dut (
    .clk(clk), .rstn(rstn),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_valid(instr_valid),
    .instr_rdata(instr_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .instret(instret), .halted(halted)
  );

  hack_cpu_mc #(.DATA_W(32), .ADDR_W(20), .RESET_VECTOR(32'h000F_FFFF)) dutW (
    .clk(clk), .rstn(rstn2),
    .instr_req(w_instr_req), .instr_addr(w_instr_addr), .instr_valid(w_instr_valid),
    .instr_rdata(w_instr_rdata), .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_ready(w_mem_ready), .mem_rdata(w_mem_rdata),
    .instret(w_instret), .halted(w_halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [15:0] rom  [0:255];
  logic [15:0] ram  [0:32767];
  logic [15:0] mram [0:32767];
  logic [14:0] fetchLog[$], rdLog[$], expFetch[$], expRd[$];
  logic [30:0] wrLog[$], expWr[$];
  int iFix, mFix, iCnt, mCnt, iTgt, mTgt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int pickWait(input int fix);
    return (fix < 0) ? int'($urandom_range(0, 2)) : fix;
  endfunction

  // Bus responders: decide valid/ready at negedge and log the transfer the next edge completes
  initial begin
    instr_valid = 1'b0; instr_rdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (instr_req) begin
        instr_valid = (iCnt >= iTgt);
        if (!instr_valid) iCnt++;
      end else begin
        instr_valid = 1'($urandom_range(0, 1));
      end
      instr_rdata = (instr_req && instr_valid) ? rom[instr_addr[7:0]] : 16'($urandom);
      if (instr_req && instr_valid) begin
        fetchLog.push_back(instr_addr);
        iCnt = 0;
        iTgt = pickWait(iFix);
      end
      if (mem_req) begin
        mem_ready = (mCnt >= mTgt);
        if (!mem_ready) mCnt++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      mem_rdata = (mem_req && mem_ready) ? ram[mem_addr] : 16'($urandom);
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          ram[mem_addr] = mem_wdata;
          wrLog.push_back({mem_addr, mem_wdata});
        end else begin
          rdLog.push_back(mem_addr);
        end
        mCnt = 0;
        mTgt = pickWait(mFix);
      end
    end
  end

  task automatic resetDut();
    rstn = 1'b0;
    step();
    step();
    fetchLog.delete(); rdLog.delete(); wrLog.delete();
    iCnt = 0; mCnt = 0;
    iTgt = pickWait(iFix);
    mTgt = pickWait(mFix);
    rstn = 1'b1;
  endtask

  function automatic logic [15:0] hackAlu(input logic [15:0] x, input logic [15:0] y,
                                          input logic [5:0] c);
    logic [15:0] xx, yy, r;
    xx = c[5] ? 16'h0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0 : y;
    yy = c[2] ? ~yy : yy;
    r  = c[1] ? 16'(xx + yy) : (xx & yy);
    return c[0] ? ~r : r;
  endfunction

  // Instruction-level reference: one loop iteration per retired instruction
  task automatic runModel(input int maxN, output int nDone);
    logic [15:0] a, d, ins, y, r, oldA;
    logic [14:0] pc;
    logic        j, stop;
    a = '0; d = '0; pc = '0; nDone = 0; stop = 1'b0;
    expFetch.delete(); expRd.delete(); expWr.delete();
    while (nDone < maxN && !stop) begin
      ins = rom[pc[7:0]];
      expFetch.push_back(pc);
      nDone++;
      if (!ins[15]) begin
        a  = {1'b0, ins[14:0]};
        pc = pc + 15'd1;
      end else begin
        if (ins[12]) begin
          y = mram[a[14:0]];
          expRd.push_back(a[14:0]);
        end else begin
          y = a;
        end
        r    = hackAlu(d, y, ins[11:6]);
        j    = (ins[2] && r[15]) || (ins[1] && r == 16'h0) || (ins[0] && !r[15] && r != 16'h0);
        oldA = a;
        if (ins[3]) begin
          mram[oldA[14:0]] = r;
          expWr.push_back({oldA[14:0], r});
        end
        if (ins[5]) a = r;
        if (ins[4]) d = r;
`ifdef HALT_DETECT_EN
        if (j && oldA[14:0] == pc) stop = 1'b1;
`endif
        pc = j ? oldA[14:0] : pc + 15'd1;
      end
    end
  endtask

  typedef struct packed {
    logic [3:0][15:0] prog;
    logic [2:0]       n;
    logic [15:0]      m3;
    logic [1:0]       wt;
    logic [14:0]      nextPc;
    logic [14:0]      memAddr;
    logic [1:0]       wrN;
    logic [14:0]      wrAddr;
    logic [15:0]      wrData;
    logic [1:0]       rdN;
    logic [14:0]      rdAddr;
    logic [4:0]       cyc;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] p0, p1, p2, p3, input int n, m3, wt, nextPc,
                              memAddr, wrN, wrAddr, wrData, rdN, rdAddr, cyc);
    vec_t v;
    v.prog = {p3, p2, p1, p0};
    v.n = 3'(n); v.m3 = 16'(m3); v.wt = 2'(wt); v.nextPc = 15'(nextPc);
    v.memAddr = 15'(memAddr); v.wrN = 2'(wrN); v.wrAddr = 15'(wrAddr); v.wrData = 16'(wrData);
    v.rdN = 2'(rdN); v.rdAddr = 15'(rdAddr); v.cyc = 5'(cyc);
    return v;
  endfunction

  vec_t        vecs[8];
  vec_t        v;
  logic [31:0] prevRet;
  int          since, cycSum, held, bad, nExp;
  logic        found;

  initial begin
    rstn = 1'b0; rstn2 = 1'b0; iFix = 0; mFix = 0;
    w_instr_valid = 1'b0; w_instr_rdata = '0; w_mem_ready = 1'b0; w_mem_rdata = '0;

    //        program                                 n  m3      wt next  mAddr wrN wrA wrD     rdN rdA cyc
    vecs[0] = mk(16'h0007, 16'hEC10, 16'h0003, 16'hE308, 4, 0,      0, 4,   3,    1,  3,  7,      0,  0,  10);
    vecs[1] = mk(16'h0007, 16'hEC10, 16'h0003, 16'hE308, 4, 0,      1, 4,   3,    1,  3,  7,      0,  0,  14);
    vecs[2] = mk(16'h0003, 16'hFC10, 16'h0009, 16'hE304, 4, 'h8000, 0, 9,   9,    0,  0,  0,      1,  3,  11);
    vecs[3] = mk(16'h0003, 16'hFC10, 16'h0009, 16'hE301, 4, 'h8000, 0, 4,   9,    0,  0,  0,      1,  3,  11);
    vecs[4] = mk(16'h0003, 16'hFDE8, 16'hFC10, 16'h0000, 3, 5,      0, 3,   6,    1,  3,  6,      2,  6,  10);
    vecs[5] = mk(16'h0005, 16'hEC10, 16'h0064, 16'hE0B7, 4, 0,      0, 100, 105,  0,  0,  0,      0,  0,  10);
    vecs[6] = mk(16'h0002, 16'hEE90, 16'hE4C8, 16'h0000, 3, 0,      0, 3,   2,    1,  2,  'hFFFD, 0,  0,  8);
    vecs[7] = mk(16'h0003, 16'hFC10, 16'hE302, 16'h0000, 3, 0,      0, 3,   3,    0,  0,  0,      1,  3,  9);

    // Wide configuration: A-instr keeps bit 30, pc wraps from the top address to 0
    step(); step();
    rstn2 = 1'b1;
    chk("w reset pc", 32'(w_instr_addr), 32'h000F_FFFF);
    found = 1'b0;
    for (int t = 0; t < 5 && !found; t++) begin step(); found = w_instr_req; end
    chk("w fetch req", 32'(found), 32'd1);
    w_instr_rdata = 32'h4000_0005; w_instr_valid = 1'b1;
    step();
    w_instr_valid = 1'b0;
    step();
    chk("w mem_addr", 32'(w_mem_addr), 32'h0000_0005);
    chk("w instret", w_instret, 32'd1);
    chk("w pc wrap", 32'(w_instr_addr), 32'd0);
    w_instr_rdata = 32'h8000_0C08; w_instr_valid = 1'b1;
    step();
    w_instr_valid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 5 && !found; t++) begin step(); found = w_mem_req && w_mem_we; end
    chk("w write req", 32'(found), 32'd1);
    chk("w wdata full A", w_mem_wdata, 32'h4000_0005);
    w_mem_ready = 1'b1;
    step();
    w_mem_ready = 1'b0;
    chk("w instret 2", w_instret, 32'd2);
    chk("w mem_req drop", 32'(w_mem_req), 32'd0);

    // Directed vector table
    for (int k = 0; k < 8; k++) begin
      v = vecs[k];
      for (int i = 0; i < 256; i++) rom[i] = 16'h0;
      for (int i = 0; i < 4; i++) rom[i] = v.prog[2'(i)];
      for (int i = 0; i < 32768; i++) ram[i] = 16'h0;
      ram[3] = v.m3;
      iFix = int'(v.wt); mFix = int'(v.wt);
      resetDut();
      prevRet = '0; since = 0; cycSum = 0;
      for (int t = 0; t < 300 && instret != 32'(v.n); t++) begin
        step();
        since++;
        if (instret != prevRet) begin
          if (instret > 32'd1) cycSum += since;
          since = 0;
          prevRet = instret;
        end
      end
      chk($sformatf("v%0d instret", k), instret, 32'(v.n));
      chk($sformatf("v%0d fetch req", k), 32'(instr_req), 32'd1);
      chk($sformatf("v%0d next pc", k), 32'(instr_addr), 32'(v.nextPc));
      chk($sformatf("v%0d mem_addr", k), 32'(mem_addr), 32'(v.memAddr));
      chk($sformatf("v%0d cycles", k), 32'(cycSum), 32'(v.cyc));
      chk($sformatf("v%0d write count", k), 32'(wrLog.size()), 32'(v.wrN));
      if (v.wrN != 2'd0 && wrLog.size() > 0)
        chk($sformatf("v%0d last write", k), 32'(wrLog[$]), 32'({v.wrAddr, v.wrData}));
      chk($sformatf("v%0d read count", k), 32'(rdLog.size()), 32'(v.rdN));
      if (v.rdN != 2'd0 && rdLog.size() > 0)
        chk($sformatf("v%0d last read", k), 32'(rdLog[$]), 32'(v.rdAddr));
    end

    // Reset while a read is stalled: request must drop at the reset edge
    for (int i = 0; i < 256; i++) rom[i] = 16'h0;
    rom[0] = 16'h0003; rom[1] = 16'hFC10;
    iFix = 0; mFix = 40;
    resetDut();
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin step(); found = mem_req && !mem_we; end
    chk("rst read stalled", 32'(found), 32'd1);
    chk("rst read addr", 32'(mem_addr), 32'd3);
    rstn = 1'b0;
    step();
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst instr_req", 32'(instr_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    step();
    mFix = 0; mCnt = 0; mTgt = 0;
    rstn = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 4 && !found; t++) begin step(); found = instr_req; end
    chk("rst fetch req", 32'(found), 32'd1);
    chk("rst fetch addr", 32'(instr_addr), 32'd0);
    chk("rst instret", instret, 32'd0);

    // Write held stable across two wait states
    for (int i = 0; i < 256; i++) rom[i] = 16'h0;
    rom[0] = 16'h0007; rom[1] = 16'hEC10; rom[2] = 16'h0003; rom[3] = 16'hE308;
    iFix = 0; mFix = 2;
    resetDut();
    held = 0; bad = 0;
    for (int t = 0; t < 100 && instret != 32'd4; t++) begin
      step();
      if (mem_req && mem_we) begin
        held++;
        if (mem_addr != 15'd3 || mem_wdata != 16'd7) bad++;
      end
    end
    chk("wr held cycles", 32'(held), 32'd3);
    chk("wr held unstable", 32'(bad), 32'd0);
    chk("wr instret", instret, 32'd4);
    chk("wr ram[3]", 32'(ram[3]), 32'd7);

    // Self-jump at address 5
    for (int i = 0; i < 256; i++) rom[i] = 16'h0;
    rom[0] = 16'h0004; rom[1] = 16'hEA87; rom[4] = 16'h0005; rom[5] = 16'hEA87;
    iFix = 0; mFix = 0;
    resetDut();
    for (int t = 0; t < 60 && instret < 32'd4; t++) step();
    chk("self-jump reached", instret, 32'd4);
`ifdef HALT_DETECT_EN
    step();
    chk("halt flag", 32'(halted), 32'd1);
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      step();
      if (instr_req || mem_req || !halted) bad++;
    end
    chk("halt idle cycles", 32'(bad), 32'd0);
    chk("halt instret frozen", instret, 32'd4);
`else
    for (int t = 0; t < 30; t++) step();
    chk("no halt flag", 32'(halted), 32'd0);
    chk("loop keeps retiring", 32'(instret > 32'd8), 32'd1);
    chk("loop fetch count", 32'(fetchLog.size() >= 7), 32'd1);
    if (fetchLog.size() >= 7) begin
      bad = 0;
      for (int i = 1; i <= 3; i++) if (fetchLog[fetchLog.size() - i] != 15'd5) bad++;
      chk("loop fetch addr 5", 32'(bad), 32'd0);
    end
`endif

    // Random program with random wait states and spurious responses
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 1) == 0)
        rom[i] = ($urandom_range(0, 7) == 0) ? {1'b0, 15'($urandom)}
                                             : 16'($urandom_range(0, 255));
      else
        rom[i] = {1'b1, 15'($urandom)};
    end
    for (int i = 0; i < 32768; i++) begin
      ram[i]  = 16'($urandom);
      mram[i] = ram[i];
    end
    runModel(300, nExp);
    iFix = -1; mFix = -1;
    resetDut();
    for (int t = 0; t < 20000 && instret != 32'(nExp); t++) step();
    chk("rand instret", instret, 32'(nExp));
    chk("rand fetch count", 32'(fetchLog.size() >= nExp), 32'd1);
    for (int i = 0; i < nExp && i < fetchLog.size(); i++) begin
      if (fetchLog[i] !== expFetch[i]) begin
        chk($sformatf("rand fetch %0d", i), 32'(fetchLog[i]), 32'(expFetch[i]));
        break;
      end
      checks++;
    end
    chk("rand read count", 32'(rdLog.size()), 32'(expRd.size()));
    for (int i = 0; i < rdLog.size() && i < expRd.size(); i++) begin
      if (rdLog[i] !== expRd[i]) begin
        chk($sformatf("rand read %0d", i), 32'(rdLog[i]), 32'(expRd[i]));
        break;
      end
      checks++;
    end
    chk("rand write count", 32'(wrLog.size()), 32'(expWr.size()));
    for (int i = 0; i < wrLog.size() && i < expWr.size(); i++) begin
      if (wrLog[i] !== expWr[i]) begin
        chk($sformatf("rand write %0d", i), 32'(wrLog[i]), 32'(expWr[i]));
        break;
      end
      checks++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
